// File: rtl/mem_responder.sv
// Memory-side responder: word-organised RAM with LATENCY wait states, byte/half/word
// store masking and load extension. Optional misaligned-access trap: MEM_MISALIGN_TRAP_EN.
module mem_responder #(
  parameter int unsigned DEPTH   = 4096,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned AW      = 12
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rmem,
  input  logic        wmem,
  input  logic [1:0]  mem_type,
  input  logic        mem_sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hold,
  output logic        err
);

  localparam logic [3:0] LAT      = 4'(LATENCY);
  localparam bit         LAT_ZERO = (LATENCY == 0);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_next;

  logic [AW+1:0] r_addr;
  logic [1:0]    r_type;
  logic          r_sign;
  logic [31:0]   r_wdata;
  logic          r_wr;
  logic [31:0]   r_rdata;
  logic [31:0]   r_mem [DEPTH];

  logic          w_req;
  logic          w_idle;
  logic          w_misalign;
  logic          w_start;
  logic          w_trap;
  logic          w_commit;
  logic          w_unused;

  logic [AW+1:0] w_a;
  logic [1:0]    w_t;
  logic          w_s;
  logic [31:0]   w_wd_sel;
  logic          w_wr;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word;
  logic [3:0]    w_be;
  logic [31:0]   w_wd;
  logic [7:0]    w_lane8;
  logic [15:0]   w_lane16;
  logic [31:0]   w_load;

  assign w_req    = rmem | wmem;
  assign w_idle   = (r_state == S_IDLE);
  assign w_unused = ^addr[31:AW+2];

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misalign = ((mem_type == 2'b01) && addr[0]) ||
                      (mem_type[1] && (addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_start = w_idle & w_req & ~w_misalign;
  assign w_trap  = w_idle & w_req & w_misalign;

  // With zero latency the access uses the live request; otherwise the captured one.
  assign w_commit = LAT_ZERO ? (rstn & w_start)
                             : (rstn & (r_state == S_WAIT) & (r_cnt == LAT));
  assign w_a      = LAT_ZERO ? addr[AW+1:0] : r_addr;
  assign w_t      = LAT_ZERO ? mem_type     : r_type;
  assign w_s      = LAT_ZERO ? mem_sign     : r_sign;
  assign w_wd_sel = LAT_ZERO ? wdata        : r_wdata;
  assign w_wr     = LAT_ZERO ? wmem         : r_wr;

  assign w_idx  = w_a[AW+1:2];
  assign w_word = r_mem[w_idx];

  // Store lane enables and lane-replicated write data
  always_comb begin
    w_be = 4'b1111;
    w_wd = w_wd_sel;
    case (w_t)
      2'b00: begin
        w_be = 4'b0001 << w_a[1:0];
        w_wd = {4{w_wd_sel[7:0]}};
      end
      2'b01: begin
        w_be = w_a[1] ? 4'b1100 : 4'b0011;
        w_wd = {2{w_wd_sel[15:0]}};
      end
      default: begin
        w_be = 4'b1111;
        w_wd = w_wd_sel;
      end
    endcase
  end

  // Load lane select and extension (mem_sign=1 zero-fills)
  always_comb begin
    w_lane8  = w_word[7:0];
    w_lane16 = w_a[1] ? w_word[31:16] : w_word[15:0];
    case (w_a[1:0])
      2'b00:   w_lane8 = w_word[7:0];
      2'b01:   w_lane8 = w_word[15:8];
      2'b10:   w_lane8 = w_word[23:16];
      default: w_lane8 = w_word[31:24];
    endcase
    case (w_t)
      2'b00:   w_load = {{24{~w_s & w_lane8[7]}}, w_lane8};
      2'b01:   w_load = {{16{~w_s & w_lane16[15]}}, w_lane16};
      default: w_load = w_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_commit && w_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_start && !LAT_ZERO) begin
          w_state_next = S_WAIT;
          w_cnt_next   = 4'd1;
        end
      end
      S_WAIT: begin
        if (r_cnt == LAT) begin
          w_state_next = S_IDLE;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  // FSM outputs; the request cycle already stalls the core
  always_comb begin
    hold = 1'b0;
    err  = 1'b0;
    if (rstn) begin
      case (r_state)
        S_IDLE: begin
          hold = w_start & !LAT_ZERO;
          err  = w_trap;
        end
        S_WAIT:  hold = (r_cnt < LAT);
        default: hold = 1'b0;
      endcase
    end
  end

  // Request capture and registered load result
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr  <= '0;
      r_type  <= 2'b00;
      r_sign  <= 1'b0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_start) begin
        r_addr  <= addr[AW+1:0];
        r_type  <= mem_type;
        r_sign  <= mem_sign;
        r_wdata <= wdata;
        r_wr    <= wmem;
      end
      if (w_trap) begin
        r_rdata <= '0;
      end else if (w_commit && !w_wr) begin
        r_rdata <= w_load;
      end
    end
  end

  assign rdata = r_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance at LATENCY=1, one at LATENCY=3.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        sel;
  logic        d_rmem, d_wmem, d_sign;
  logic [1:0]  d_type;
  logic [31:0] d_addr, d_wdata;
  logic [31:0] rdata1, rdata3;
  logic        hold1, hold3, err1, err3;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] rd;
  int          hc;
  logic        ev;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(4096), .LATENCY(1), .AW(12)) u_dut1 (
    .clk(clk), .rstn(rstn), .rmem(d_rmem & ~sel), .wmem(d_wmem & ~sel),
    .mem_type(d_type), .mem_sign(d_sign), .addr(d_addr), .wdata(d_wdata),
    .rdata(rdata1), .hold(hold1), .err(err1)
  );

  mem_responder #(.DEPTH(4096), .LATENCY(3), .AW(12)) u_dut3 (
    .clk(clk), .rstn(rstn), .rmem(d_rmem & sel), .wmem(d_wmem & sel),
    .mem_type(d_type), .mem_sign(d_sign), .addr(d_addr), .wdata(d_wdata),
    .rdata(rdata3), .hold(hold3), .err(err3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic clear_req();
    d_rmem = 1'b0; d_wmem = 1'b0; d_type = 2'b10; d_sign = 1'b0;
    d_addr = '0;   d_wdata = '0;
  endtask

  // One access on the selected instance; counts hold-high cycles, returns err of the request cycle
  task automatic acc(input logic rm, input logic wm, input logic [1:0] typ, input logic sgn,
                     input logic [31:0] a, input logic [31:0] wd, input logic keep,
                     input logic [31:0] a2, output logic [31:0] rd_o, output int hc_o,
                     output logic err_o);
    @(negedge clk);
    d_rmem = rm; d_wmem = wm; d_type = typ; d_sign = sgn; d_addr = a; d_wdata = wd;
    #1;
    err_o = sel ? err3 : err1;
    hc_o  = (sel ? hold3 : hold1) ? 1 : 0;
    @(negedge clk);
    if (keep) d_addr = a2;
    else clear_req();
    #1;
    while ((sel ? hold3 : hold1) && hc_o < 20) begin
      hc_o++;
      @(negedge clk);
      #1;
    end
    clear_req();
    @(negedge clk);
    #1;
    rd_o = sel ? rdata3 : rdata1;
  endtask

  initial begin
    rstn = 1'b0;
    sel  = 1'b0;
    clear_req();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    #1;
    check("rst_rdata", rdata1, 32'h0);
    check("rst_hold",  32'(hold1), 32'h0);
    check("rst_err",   32'(err1), 32'h0);

    // LATENCY=1 word write/read
    acc(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 0, rd, hc, ev);
    check("w_word_hold", 32'(hc), 32'd1);
    acc(1, 0, 2'b10, 0, 32'h10, 32'h0, 0, 0, rd, hc, ev);
    check("r_word", rd, 32'hDEADBEEF);
    check("r_word_hold", 32'(hc), 32'd1);

    // byte store and byte loads
    acc(0, 1, 2'b10, 0, 32'h10, 32'h11223344, 0, 0, rd, hc, ev);
    acc(0, 1, 2'b00, 0, 32'h13, 32'h123456A5, 0, 0, rd, hc, ev);
    acc(1, 0, 2'b10, 0, 32'h10, 32'h0, 0, 0, rd, hc, ev);
    check("byte_store_word", rd, 32'hA5223344);
    acc(1, 0, 2'b00, 0, 32'h13, 32'h0, 0, 0, rd, hc, ev);
    check("lb_sext", rd, 32'hFFFFFFA5);
    acc(1, 0, 2'b00, 1, 32'h13, 32'h0, 0, 0, rd, hc, ev);
    check("lbu_zext", rd, 32'h000000A5);
    acc(1, 0, 2'b00, 0, 32'h11, 32'h0, 0, 0, rd, hc, ev);
    check("lb_lane1", rd, 32'h00000033);

    // half store and half loads
    acc(0, 1, 2'b10, 0, 32'h20, 32'h11223344, 0, 0, rd, hc, ev);
    acc(0, 1, 2'b01, 0, 32'h22, 32'hFFFF8001, 0, 0, rd, hc, ev);
    acc(1, 0, 2'b10, 0, 32'h20, 32'h0, 0, 0, rd, hc, ev);
    check("half_store_word", rd, 32'h80013344);
    acc(1, 0, 2'b01, 0, 32'h22, 32'h0, 0, 0, rd, hc, ev);
    check("lh_sext", rd, 32'hFFFF8001);
    acc(1, 0, 2'b01, 1, 32'h22, 32'h0, 0, 0, rd, hc, ev);
    check("lhu_zext", rd, 32'h00008001);
    acc(1, 0, 2'b01, 0, 32'h20, 32'h0, 0, 0, rd, hc, ev);
    check("lh_low", rd, 32'h00003344);

    // address wraps modulo DEPTH
    acc(1, 0, 2'b10, 0, 32'h4010, 32'h0, 0, 0, rd, hc, ev);
    check("addr_wrap", rd, 32'hA5223344);

    // simultaneous read and write: write wins, rdata unchanged
    acc(1, 1, 2'b10, 0, 32'h40, 32'h55667788, 0, 0, rd, hc, ev);
    check("rw_rdata_kept", rd, 32'hA5223344);
    acc(1, 0, 2'b10, 0, 32'h40, 32'h0, 0, 0, rd, hc, ev);
    check("rw_write_done", rd, 32'h55667788);

    // misaligned word read
    acc(1, 0, 2'b10, 0, 32'h12, 32'h0, 0, 0, rd, hc, ev);
`ifdef MEM_MISALIGN_TRAP_EN
    check("mis_err",   32'(ev), 32'h1);
    check("mis_hold",  32'(hc), 32'h0);
    check("mis_rdata", rd, 32'h0);
`else
    check("mis_err",   32'(ev), 32'h0);
    check("mis_hold",  32'(hc), 32'h1);
    check("mis_rdata", rd, 32'hA5223344);
`endif

    // LATENCY=3: address change during WAIT is ignored
    sel = 1'b1;
    acc(0, 1, 2'b10, 0, 32'h10, 32'hAAAA0001, 0, 0, rd, hc, ev);
    check("l3_w_hold", 32'(hc), 32'd3);
    acc(0, 1, 2'b10, 0, 32'h20, 32'hBBBB0002, 0, 0, rd, hc, ev);
    acc(1, 0, 2'b10, 0, 32'h10, 32'h0, 1, 32'h20, rd, hc, ev);
    check("l3_r_hold", 32'(hc), 32'd3);
    check("l3_r_captured", rd, 32'hAAAA0001);

    // reset during WAIT aborts the write
    acc(0, 1, 2'b10, 0, 32'h30, 32'hCAFEF00D, 0, 0, rd, hc, ev);
    @(negedge clk);
    d_wmem = 1'b1; d_type = 2'b10; d_addr = 32'h30; d_wdata = 32'h12345678;
    #1;
    check("abort_req_hold", 32'(hold3), 32'h1);
    @(negedge clk);
    clear_req();
    #1;
    rstn = 1'b0;
    #1;
    check("abort_hold", 32'(hold3), 32'h0);
    check("abort_rdata", rdata3, 32'h0);
    #1;
    rstn = 1'b1;
    acc(1, 0, 2'b10, 0, 32'h30, 32'h0, 0, 0, rd, hc, ev);
    check("abort_word_kept", rd, 32'hCAFEF00D);
    check("abort_read_hold", 32'(hc), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
